// File: rtl/bk_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : bk_adder_pipe                                                |
// | Description : Pipelined Brent-Kung parallel-prefix adder with valid/ready  |
// |               handshakes on both sides and an accepted-beat counter.       |
// |               sum = {carry-out, a + b + cin}, unsigned, WIDTH+1 bits.      |
// | Optional    : BK_APPROX_EN - when defined, the low APPROX_BITS bits of the |
// |               result are a|b and the carry into bit APPROX_BITS is         |
// |               a[APPROX_BITS-1] & b[APPROX_BITS-1] (cin ignored when        |
// |               APPROX_BITS > 0).                                            |
// | Ports       : clk       - rising-edge clock                                |
// |               rst       - asynchronous active-low reset                    |
// |               in_valid  / in_ready  - operand handshake (a, b, cin)        |
// |               out_valid / out_ready - result handshake (sum)               |
// |               op_count  - beats accepted since reset (wraps)               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module bk_adder_pipe #(
   parameter int WIDTH       = 16,
   parameter int PIPE_STAGES = 2,
   parameter int APPROX_BITS = 7,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH:0]   sum,
   output logic [CNT_W-1:0] op_count
);

   // Level numbering: 0 = g/p pre-processing, 1..LOG_W = up-sweep,
   // LOG_W+1..2*LOG_W-1 = down-sweep, 2*LOG_W = final XOR.
   localparam int LOG_W = $clog2(WIDTH);
   localparam int N_LVL = 2 * LOG_W + 1;
   localparam int N_GP  = 2 * LOG_W;   // index of the post (XOR) level

`ifdef BK_APPROX_EN
   localparam int N_APX = APPROX_BITS;
`else
   // The exact build has no approximate lanes; APPROX_BITS is inert.
   localparam int N_APX = 0;
   localparam int unused_approx_bits = APPROX_BITS;
`endif

   // -------------------------------------------------------------------------
   // Flow control: a single global stall freezes every rank at once, so no
   // beat can be dropped or duplicated and bubbles move freely otherwise.
   // -------------------------------------------------------------------------
   logic stall;
   logic out_valid_q, out_valid_d;
   logic [WIDTH:0] sum_q, sum_d;

   assign stall     = out_valid_q & ~out_ready;
   assign in_ready  = rst & ~stall;
   assign out_valid = out_valid_q;
   assign sum       = sum_q;

   // -------------------------------------------------------------------------
   // Accepted-beat counter
   // -------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (in_valid && in_ready) begin
         cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign op_count = cnt_q;

   // -------------------------------------------------------------------------
   // Input rank: captures the operands on acceptance.
   // -------------------------------------------------------------------------
   logic             in_v_q, in_v_d;
   logic [WIDTH-1:0] in_a_q, in_a_d;
   logic [WIDTH-1:0] in_b_q, in_b_d;
   logic             in_c_q, in_c_d;

   always_comb begin
      in_v_d = in_v_q;
      in_a_d = in_a_q;
      in_b_d = in_b_q;
      in_c_d = in_c_q;
      if (!stall) begin
         in_v_d = in_valid;
         in_a_d = a;
         in_b_d = b;
         in_c_d = cin;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         in_v_q <= 1'b0;
         in_a_q <= '0;
         in_b_q <= '0;
         in_c_q <= 1'b0;
      end else begin
         in_v_q <= in_v_d;
         in_a_q <= in_a_d;
         in_b_q <= in_b_d;
         in_c_q <= in_c_d;
      end
   end

   // -------------------------------------------------------------------------
   // Per-level bundles. lvl_*_o[t] is the combinational result of level t;
   // lvl_*_i[t] is what level t sees (registered or straight-through).
   //   g : group generate, p : group propagate,
   //   x : per-bit XOR term for the final sum, c : carry into bit 0.
   // -------------------------------------------------------------------------
   logic             lvl_v_o [N_GP];
   logic [WIDTH-1:0] lvl_g_o [N_GP];
   logic [WIDTH-1:0] lvl_p_o [N_GP];
   logic [WIDTH-1:0] lvl_x_o [N_GP];
   logic             lvl_c_o [N_GP];

   logic             lvl_v_i [1:N_GP];
   logic [WIDTH-1:0] lvl_g_i [1:N_GP];
   logic [WIDTH-1:0] lvl_p_i [1:N_GP];
   logic [WIDTH-1:0] lvl_x_i [1:N_GP];
   logic             lvl_c_i [1:N_GP];

   // -------------------------------------------------------------------------
   // Level 0: bitwise generate/propagate. cin enters as G[-1], folded into
   // bit 0 so that G[0] is already the prefix over [0:-1]; the propagate of
   // that group is zero because nothing lies below G[-1].
   // Approximate lanes contribute no carry except the top one, whose
   // generate is a&b and whose propagate is forced low, which gives exactly
   // the a[N-1]&b[N-1] carry into the first exact bit.
   // -------------------------------------------------------------------------
   logic [WIDTH-1:0] pre_g, pre_p, pre_x;

   generate
      for (genvar i = 0; i < WIDTH; i++) begin : g_pre_bit
         if (i < N_APX) begin : g_apx
            if (i == N_APX - 1) begin : g_top
               assign pre_g[i] = in_a_q[i] & in_b_q[i];
            end else begin : g_low
               assign pre_g[i] = 1'b0;
            end
            assign pre_p[i] = 1'b0;
            assign pre_x[i] = in_a_q[i] | in_b_q[i];
         end else if (i == 0) begin : g_lsb
            assign pre_g[i] = (in_a_q[i] & in_b_q[i]) |
                              ((in_a_q[i] ^ in_b_q[i]) & in_c_q);
            assign pre_p[i] = 1'b0;
            assign pre_x[i] = in_a_q[i] ^ in_b_q[i];
         end else begin : g_exact
            assign pre_g[i] = in_a_q[i] & in_b_q[i];
            assign pre_p[i] = in_a_q[i] ^ in_b_q[i];
            assign pre_x[i] = in_a_q[i] ^ in_b_q[i];
         end
      end
   endgenerate

   assign lvl_v_o[0] = in_v_q;
   assign lvl_g_o[0] = pre_g;
   assign lvl_p_o[0] = pre_p;
   assign lvl_x_o[0] = pre_x;
   // With approximate lanes present the carry into bit 0 is irrelevant.
   assign lvl_c_o[0] = (N_APX == 0) ? in_c_q : 1'b0;

   // -------------------------------------------------------------------------
   // Levels 1..N_GP-1: Brent-Kung up-sweep then down-sweep.
   //   up-sweep level k  : nodes with (i+1) % 2^k == 0 absorb i-2^(k-1).
   //   down-sweep level k: nodes with (i+1) % 2^k == 2^(k-1), above the
   //                       first block, absorb the finished prefix at
   //                       i-2^(k-1). k runs LOG_W-1 down to 1.
   // Untouched nodes pass straight through.
   // -------------------------------------------------------------------------
   generate
      for (genvar t = 1; t < N_GP; t++) begin : g_lvl
         localparam bit UP   = (t <= LOG_W);
         localparam int K    = UP ? t : (N_GP - t);
         localparam int SPAN = 1 << (K - 1);
         localparam int BLK  = 1 << K;

         logic [WIDTH-1:0] g_n, p_n;

         for (genvar i = 0; i < WIDTH; i++) begin : g_node
            if (UP && (((i + 1) % BLK) == 0)) begin : g_up_op
               assign g_n[i] = lvl_g_i[t][i] | (lvl_p_i[t][i] & lvl_g_i[t][i-SPAN]);
               assign p_n[i] = lvl_p_i[t][i] & lvl_p_i[t][i-SPAN];
            end else if (!UP && (((i + 1) % BLK) == SPAN) && ((i + 1) > BLK)) begin : g_dn_op
               assign g_n[i] = lvl_g_i[t][i] | (lvl_p_i[t][i] & lvl_g_i[t][i-SPAN]);
               assign p_n[i] = lvl_p_i[t][i];
            end else begin : g_pass
               assign g_n[i] = lvl_g_i[t][i];
               assign p_n[i] = lvl_p_i[t][i];
            end
         end

         assign lvl_v_o[t] = lvl_v_i[t];
         assign lvl_g_o[t] = g_n;
         assign lvl_p_o[t] = p_n;
         assign lvl_x_o[t] = lvl_x_i[t];
         assign lvl_c_o[t] = lvl_c_i[t];
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Register boundaries. PIPE_STAGES ranks are spread evenly over the N_LVL
   // levels: a rank follows level t whenever floor(t*S/N) steps up. The last
   // level (post) always ends in a rank -- the output register below -- so
   // PIPE_STAGES-1 of these boundaries are real registers.
   // -------------------------------------------------------------------------
   generate
      for (genvar t = 0; t < N_GP; t++) begin : g_bnd
         localparam bit CUT = (((t + 1) * PIPE_STAGES) / N_LVL) !=
                              ((t * PIPE_STAGES) / N_LVL);
         if (CUT) begin : g_reg
            logic             v_q, v_d;
            logic [WIDTH-1:0] g_q, g_d;
            logic [WIDTH-1:0] p_q, p_d;
            logic [WIDTH-1:0] x_q, x_d;
            logic             c_q, c_d;

            always_comb begin
               v_d = v_q;
               g_d = g_q;
               p_d = p_q;
               x_d = x_q;
               c_d = c_q;
               if (!stall) begin
                  v_d = lvl_v_o[t];
                  g_d = lvl_g_o[t];
                  p_d = lvl_p_o[t];
                  x_d = lvl_x_o[t];
                  c_d = lvl_c_o[t];
               end
            end

            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  v_q <= 1'b0;
                  g_q <= '0;
                  p_q <= '0;
                  x_q <= '0;
                  c_q <= 1'b0;
               end else begin
                  v_q <= v_d;
                  g_q <= g_d;
                  p_q <= p_d;
                  x_q <= x_d;
                  c_q <= c_d;
               end
            end

            assign lvl_v_i[t+1] = v_q;
            assign lvl_g_i[t+1] = g_q;
            assign lvl_p_i[t+1] = p_q;
            assign lvl_x_i[t+1] = x_q;
            assign lvl_c_i[t+1] = c_q;
         end else begin : g_wire
            assign lvl_v_i[t+1] = lvl_v_o[t];
            assign lvl_g_i[t+1] = lvl_g_o[t];
            assign lvl_p_i[t+1] = lvl_p_o[t];
            assign lvl_x_i[t+1] = lvl_x_o[t];
            assign lvl_c_i[t+1] = lvl_c_o[t];
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Post level: after the down-sweep, G[i] is the carry out of bit i, so the
   // carry into bit i is G[i-1] (cin for bit 0) and the top G is carry-out.
   // -------------------------------------------------------------------------
   logic [WIDTH:0] post_s;

   assign post_s = {lvl_g_i[N_GP][WIDTH-1],
                    lvl_x_i[N_GP] ^ {lvl_g_i[N_GP][WIDTH-2:0], lvl_c_i[N_GP]}};

   always_comb begin
      out_valid_d = out_valid_q;
      sum_d       = sum_q;
      if (!stall) begin
         out_valid_d = lvl_v_i[N_GP];
         sum_d       = post_s;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_q <= 1'b0;
         sum_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         sum_q       <= sum_d;
      end
   end

   // Group propagates are dead once the prefix tree is complete; cin is
   // dead when approximate lanes are present.
   logic unused_bits;
   assign unused_bits = ^{lvl_p_i[N_GP], in_c_q};

endmodule
`default_nettype wire

// File: tb/tb_bk_adder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_bk_adder_pipe                                             |
// | Description : Self-checking bench for bk_adder_pipe. A scoreboard queue    |
// |               holds arithmetic results for every accepted beat; a monitor  |
// |               compares sum, handshake and op_count on every falling edge.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_bk_adder_pipe;

   localparam int W  = 16;
   localparam int P  = 2;
   localparam int AB = 7;
   localparam int CW = 32;
   localparam int AB_IDX = (AB > 0) ? AB - 1 : 0;

`ifdef BK_APPROX_EN
   localparam logic [W:0] EXP_CHAIN = 17'h0FFFF;
   localparam logic [W:0] EXP_FULL  = 17'h1FFFF;
   localparam logic [W:0] EXP_CIN   = 17'h00000;
   localparam logic [W:0] EXP_APX   = 17'h000FF;
`else
   localparam logic [W:0] EXP_CHAIN = 17'h10000;
   localparam logic [W:0] EXP_FULL  = 17'h1FFFF;
   localparam logic [W:0] EXP_CIN   = 17'h00001;
   localparam logic [W:0] EXP_APX   = 17'h00101;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  a_i = '0;
   logic [W-1:0]  b_i = '0;
   logic          cin_i = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W:0]    sum;
   logic [CW-1:0] op_count;

   int            n_cmp = 0;
   int            n_bad = 0;
   int            pop_total = 0;
   logic [CW-1:0] exp_cnt = '0;
   logic [W:0]    exp_q [$];

   bk_adder_pipe #(
      .WIDTH       (W),
      .PIPE_STAGES (P),
      .APPROX_BITS (AB),
      .CNT_W       (CW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a_i),
      .b         (b_i),
      .cin       (cin_i),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .op_count  (op_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference arithmetic, written directly from the adder's definition.
   function automatic logic [W:0] ref_sum(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic ci);
      longint unsigned r;
`ifdef BK_APPROX_EN
      longint unsigned lo, hi, mask;
      logic cy;
      if (AB > 0) begin
         mask = (64'd1 << AB) - 64'd1;
         lo   = 64'(x | y) & mask;
         cy   = x[AB_IDX] & y[AB_IDX];
         hi   = (64'(x) >> AB) + (64'(y) >> AB) + 64'(cy);
         r    = (hi << AB) | lo;
      end else begin
         r = 64'(x) + 64'(y) + 64'(ci);
      end
`else
      r = 64'(x) + 64'(y) + 64'(ci);
`endif
      return (W+1)'(r);
   endfunction

   // Monitor: inputs change at posedge+1, so everything is stable here.
   always @(negedge clk) begin
      if (!rst) begin
         exp_q.delete();
         exp_cnt = '0;
      end else begin
         check("op_count", 64'(op_count), 64'(exp_cnt));
         check("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'd0);
            end else begin
               check("sum", 64'(sum), 64'(exp_q[0]));
               if (out_ready) begin
                  void'(exp_q.pop_front());
                  pop_total++;
               end
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(ref_sum(a_i, b_i, cin_i));
            exp_cnt = exp_cnt + 1'b1;
         end
      end
   end

   // One beat into an idle pipe; checks exact latency and value.
   task automatic send_one(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                           input logic [W:0] expv, input string tag);
      @(posedge clk); #1;
      a_i = ta; b_i = tb; cin_i = tc; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;      // accepted at this edge
      in_valid = 1'b0;
      for (int k = 0; k < P; k++) begin
         check({tag, "_early"}, 64'(out_valid), 64'd0);
         @(posedge clk); #1;
      end
      check({tag, "_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_sum"}, 64'(sum), 64'(expv));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int idx;
      int p0;

      // Reset state
      #2 rst = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_sum", 64'(sum), 64'd0);
      check("rst_op_count", 64'(op_count), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;

      // Latency, carry chain, carry-in, lower-part behaviour
      send_one(16'hFFFF, 16'h0001, 1'b0, EXP_CHAIN, "chain");
      send_one(16'hFFFF, 16'hFFFF, 1'b1, EXP_FULL,  "full");
      send_one(16'h0000, 16'h0000, 1'b1, EXP_CIN,   "cin");
      send_one(16'h00FF, 16'h0001, 1'b1, EXP_APX,   "apx");

      // Reset mid-stream with the pipe full and stalled
      out_ready = 1'b0;
      for (int i = 0; i < P + 3; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1; a_i = W'($urandom); b_i = W'($urandom); cin_i = 1'($urandom_range(0, 1));
      end
      check("prefill_out_valid", 64'(out_valid), 64'd1);
      @(posedge clk); #3;
      rst = 1'b0;
      in_valid = 1'b0;
      #1;
      check("mid_rst_out_valid", 64'(out_valid), 64'd0);
      check("mid_rst_sum", 64'(sum), 64'd0);
      check("mid_rst_op_count", 64'(op_count), 64'd0);
      check("mid_rst_in_ready", 64'(in_ready), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 2 * P + 4; i++) begin
         @(posedge clk); #1;
         check("post_rst_idle", 64'(out_valid), 64'd0);
      end

      // Backpressure: 10 beats a=i, b=3i, sink stalls during cycles 3..7
      idx = 0;
      p0  = pop_total;
      for (int c = 0; c < 80 && (pop_total - p0) < 10; c++) begin
         @(posedge clk); #1;
         out_ready = !(c >= 3 && c <= 7);
         if (idx < 10) begin
            in_valid = 1'b1;
            a_i      = W'(idx);
            b_i      = W'(3 * idx);
            cin_i    = 1'b0;
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
      end
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check("bp_results", 64'(pop_total - p0), 64'd10);
      check("bp_op_count", 64'(op_count), 64'd10);

      // Throughput: 1000 back-to-back random beats
      p0 = pop_total;
      for (int i = 0; i < 1000; i++) begin
         @(posedge clk); #1;
         in_valid = 1'b1;
         a_i      = W'($urandom);
         b_i      = W'($urandom);
         cin_i    = 1'($urandom_range(0, 1));
         @(negedge clk);
         check("tput_in_ready", 64'(in_ready), 64'd1);
      end
      @(posedge clk); #1;       // last beat accepted at this edge
      in_valid = 1'b0;
      repeat (P - 1) @(posedge clk);
      @(negedge clk); #1;
      check("tput_before_last", 64'(pop_total - p0), 64'd999);
      @(posedge clk);
      @(negedge clk); #1;
      check("tput_total", 64'(pop_total - p0), 64'd1000);

      repeat (P + 2) @(posedge clk);
      #1;
      check("drain_empty", 64'(out_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
